// File: rtl/sequential_multiplier_pkg.sv
// Shared types for the shift-and-add sequential multiplier.
package sequential_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/n_bit_ripple_carry_adder.sv
// BIT_NUM-bit ripple-carry adder; sgn_op2 selects op1 - op2 via inverted op2 and carry-in.
module n_bit_ripple_carry_adder #(
    parameter int unsigned BIT_NUM = 8
) (
    input  logic [BIT_NUM-1:0] op1,
    input  logic [BIT_NUM-1:0] op2,
    input  logic               sgn_op2,
    output logic [BIT_NUM-1:0] sum,
    output logic               carry_o
);

    logic [BIT_NUM:0]   carry;
    logic [BIT_NUM-1:0] op2_eff;

    assign op2_eff  = op2 ^ {BIT_NUM{sgn_op2}};
    assign carry[0] = sgn_op2;

    for (genvar i = 0; i < int'(BIT_NUM); i++) begin : g_fa
        assign sum[i]     = op1[i] ^ op2_eff[i] ^ carry[i];
        assign carry[i+1] = (op1[i] & op2_eff[i]) | (carry[i] & (op1[i] ^ op2_eff[i]));
    end

    assign carry_o = carry[BIT_NUM];

endmodule

// File: rtl/sequential_multiplier.sv
// Unsigned shift-and-add multiplier: one partial product per cycle, valid/ready on both sides.
module sequential_multiplier
    import sequential_multiplier_pkg::*;
#(
    parameter int unsigned BIT_NUM = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [BIT_NUM-1:0]   op1_i,
    input  logic [BIT_NUM-1:0]   op2_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [2*BIT_NUM-1:0] result_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int unsigned PROD_W = 2 * BIT_NUM;
    localparam int unsigned CNT_W  = $clog2(BIT_NUM + 1);

    mul_state_t         state;
    logic [BIT_NUM-1:0] mcand;
    logic [PROD_W-1:0]  prod;
    logic [CNT_W-1:0]   cnt;

    logic [BIT_NUM-1:0] add_sum;
    logic               add_carry;

    // Accumulator (upper half of prod) plus multiplicand.
    n_bit_ripple_carry_adder #(
        .BIT_NUM (BIT_NUM)
    ) u_adder (
        .op1     (prod[PROD_W-1:BIT_NUM]),
        .op2     (mcand),
        .sgn_op2 (1'b0),
        .sum     (add_sum),
        .carry_o (add_carry)
    );

    assign result_o = prod;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state   <= IDLE;
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        mcand   <= op1_i;
                        prod    <= {{BIT_NUM{1'b0}}, op2_i};
                        cnt     <= '0;
                        state   <= BUSY;
                        ready_o <= 1'b0;
                    end
                end
                BUSY: begin
                    // Adder carry lands in the top bit as the whole product shifts right.
                    if (prod[0]) begin
                        prod <= {add_carry, add_sum, prod[BIT_NUM-1:1]};
                    end else begin
                        prod <= {1'b0, prod[PROD_W-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIT_NUM - 1)) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/sequential_multiplier.md
# sequential_multiplier

Multi-cycle unsigned shift-and-add multiplier. It sits directly downstream of `n_bit_ripple_carry_adder` and consumes its `sum`/`carry_o` outputs: one adder instance performs the partial-product accumulation, one bit per cycle. It gives the execution stage a small-area integer multiply path, using a valid/ready handshake on both sides.

## Interface
- `BIT_NUM`, 8, operand width in bits (≥ 2).
- `clk_i` input 1: clock, rising-edge.
- `arst_ni` input 1: asynchronous active-low reset.
- `op1_i` input BIT_NUM: multiplicand, unsigned.
- `op2_i` input BIT_NUM: multiplier, unsigned.
- `valid_i` input 1: operands valid.
- `ready_o` output 1: block can accept operands.
- `result_o` output 2*BIT_NUM: product, unsigned.
- `valid_o` output 1: `result_o` is valid.
- `ready_i` input 1: consumer accepts the result.

## Operation
- Internal registers:
  - `mcand` (BIT_NUM): multiplicand.
  - `prod` (2*BIT_NUM): upper half is the accumulator, lower half is the remaining multiplier bits.
  - `cnt` ($clog2(BIT_NUM+1) bits).
  - `state`.
- FSM states: IDLE, BUSY, DONE.
- **IDLE:** `ready_o=1`.
  - On `valid_i && ready_o` at a clock edge: `mcand←op1_i`, `prod←{0, op2_i}`, `cnt←0`, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY:** `ready_o=0`, `valid_i` is ignored. Each cycle:
  - Adder inputs: `op1=prod[2*BIT_NUM-1:BIT_NUM]`, `op2=mcand`, `sgn_op2=0`.
  - If `prod[0]=1`: `prod←{carry_o, sum, prod[BIT_NUM-1:1]}`.
  - Else: `prod←{1'b0, prod[2*BIT_NUM-1:1]}`.
  - `cnt←cnt+1`. When `cnt==BIT_NUM-1` this cycle, go to DONE.
- **DONE:** `valid_o=1`; `result_o=prod`, held stable.
  - On `ready_i` at a clock edge: go to IDLE.
  - While `ready_i=0`: hold `result_o` and `valid_o`.
- `result_o` is driven from `prod` in every state. It is only meaningful while `valid_o=1`.
- Width rule: the accumulator carry is captured into bit 2*BIT_NUM-1 during the shift, so no overflow is possible. The full product fits in 2*BIT_NUM bits.
- Zero operands need no special case. They take the same latency.

## Timing
- Reset (`arst_ni=0`, takes effect immediately, asynchronous):
  - state=IDLE, `prod=0`, `mcand=0`, `cnt=0`.
  - Outputs: `ready_o=1`, `valid_o=0`, `result_o=0`.
- Handshake accepted at edge N. BUSY occupies edges N+1 … N+BIT_NUM. `valid_o` rises right after edge N+BIT_NUM. Latency is BIT_NUM cycles.
- Result taken at edge M (`valid_o && ready_i`). `ready_o` rises right after M. The next accept is at edge M+1 at the earliest, so there is no back-to-back issue.
- Throughput is at best one product per BIT_NUM+2 cycles.
- Simultaneous events:
  - `valid_i` asserted in DONE: ignored.
  - `ready_i` asserted outside DONE: ignored.
- Reset asserted mid-BUSY or mid-DONE: the operation is abandoned and no result is produced. After release the block is in IDLE with the reset values above.
- The adder path is combinational within one cycle. The critical path is the BIT_NUM-bit ripple chain plus the mux into `prod`.

## Structure
- Package `sequential_multiplier_pkg` holds the state typedef `mul_state_t` {IDLE, BUSY, DONE}.
- One sub-module: `n_bit_ripple_carry_adder #(.BIT_NUM(BIT_NUM))`, with `sgn_op2` tied to 0.
- The counter, FSM and `prod` shift register are in the top level. Expected size is about 150 lines.

## Test plan
- BIT_NUM=8. Send 0x0F × 0x0F with `ready_i=1`: `valid_o` goes high exactly 8 cycles after accept with `result_o=0x00E1`, then `ready_o` returns to 1.
- Send 0xFF × 0xFF: `result_o=0xFE01`, which checks carry capture into the top bit. Send 0x00 × 0xAB: `result_o=0x0000` with the same 8-cycle latency.
- Backpressure: send 0x12 × 0x34 and hold `ready_i=0` for 5 cycles after `valid_o`.
  - `result_o` stays 0x03A8 and `valid_o` stays 1 throughout.
  - A new `valid_i` pulse during that window is ignored.
  - The product is consumed on `ready_i`.
- Reset mid-operation: assert `arst_ni=0` 3 cycles into BUSY.
  - Immediately: `ready_o=1`, `valid_o=0`, `result_o=0`.
  - Next send after release, 0x80 × 0x02: gives 0x0100.
- Random: 1000 random operand pairs with random `ready_i` delays (0–4 cycles), checked against a golden `op1*op2`. Also check `valid_i` held high continuously: each result is accepted exactly once, with BIT_NUM+2-cycle spacing.
